// File: rtl/scan_ctrl_chain_if.sv
// Pad-side scan/control signal bundle for scan_ctrl_chain.
// The master drives the scan pads; the slave is the control register.
interface scan_ctrl_chain_if #(
    parameter int unsigned WIDTH = 12
);
    logic             SCAN_EN;
    logic             SCAN_IN;
    logic             LOAD;
    logic             CAPTURE;
    logic             SCAN_OUT;
    logic [WIDTH-1:0] CTRL;
    logic             FRAME_ERR;
    logic             LOAD_DONE;

    modport master (
        output SCAN_EN, SCAN_IN, LOAD, CAPTURE,
        input  SCAN_OUT, CTRL, FRAME_ERR, LOAD_DONE
    );

    modport slave (
        input  SCAN_EN, SCAN_IN, LOAD, CAPTURE,
        output SCAN_OUT, CTRL, FRAME_ERR, LOAD_DONE
    );
endinterface

// File: rtl/scan_ctrl_chain.sv
// Serial-scan control register: shift chain, shadow CTRL register committed on a
// LOAD edge only when exactly WIDTH bits were shifted, plus CTRL readback via CAPTURE.
module scan_ctrl_chain #(
    parameter int unsigned      WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SYNC_LOAD = 1'b1
) (
    input  logic              SCAN_CLK,
    input  logic              RESET,
    scan_ctrl_chain_if.slave  bus
);
    localparam int unsigned   CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] ctrl;
    logic [CW-1:0]    cnt;
    logic             frame_err;
    logic             load_done;
    logic             ls;
    logic             lprev;
    logic             load_evt;
    logic             frame_ok;

    generate
        if (SYNC_LOAD) begin : g_sync
            logic [1:0] sync;
            always_ff @(posedge SCAN_CLK or posedge RESET) begin
                if (RESET) sync <= '0;
                else       sync <= {sync[0], bus.LOAD};
            end
            assign ls = sync[1];
        end else begin : g_direct
            assign ls = bus.LOAD;
        end
    endgenerate

    always_ff @(posedge SCAN_CLK or posedge RESET) begin
        if (RESET) lprev <= 1'b0;
        else       lprev <= ls;
    end

    assign load_evt = ls & ~lprev;
    assign frame_ok = (cnt == CNT_FULL);

    // Load decision reads pre-edge sr/cnt/ctrl, so a same-edge shift or
    // capture never disturbs the frame being committed.
    always_ff @(posedge SCAN_CLK or posedge RESET) begin
        if (RESET) begin
            sr        <= '0;
            ctrl      <= RESET_VAL;
            cnt       <= '0;
            frame_err <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= load_evt & frame_ok;

            if (load_evt) begin
                if (frame_ok) begin
                    ctrl      <= sr;
                    frame_err <= 1'b0;
                end else begin
                    frame_err <= 1'b1;
                end
            end

            if (bus.SCAN_EN)      sr <= {sr[WIDTH-2:0], bus.SCAN_IN};
            else if (bus.CAPTURE) sr <= ctrl;

            // A shift on the load edge is the first bit of the next frame.
            if (load_evt) begin
                cnt <= bus.SCAN_EN ? CW'(1) : CW'(0);
            end else if (bus.SCAN_EN) begin
                if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
            end else if (bus.CAPTURE) begin
                cnt <= CW'(0);
            end
        end
    end

    assign bus.SCAN_OUT  = sr[WIDTH-1];
    assign bus.CTRL      = ctrl;
    assign bus.FRAME_ERR = frame_err;
    assign bus.LOAD_DONE = load_done;
endmodule

// File: tb/tb_scan_ctrl_chain.sv
// Scoreboard bench for scan_ctrl_chain: instance A (SYNC_LOAD=1, RESET_VAL=0) and
// instance B (SYNC_LOAD=0, RESET_VAL=12'h801), directed frames with hand-computed results.
module tb_scan_ctrl_chain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    scan_ctrl_chain_if #(.WIDTH(12)) ia ();
    scan_ctrl_chain_if #(.WIDTH(12)) ib ();

    scan_ctrl_chain #(.WIDTH(12), .RESET_VAL(12'h000), .SYNC_LOAD(1'b1)) dut_a (
        .SCAN_CLK(clk), .RESET(rst), .bus(ia)
    );
    scan_ctrl_chain #(.WIDTH(12), .RESET_VAL(12'h801), .SYNC_LOAD(1'b0)) dut_b (
        .SCAN_CLK(clk), .RESET(rst), .bus(ib)
    );

    // mask bits: 0 ctrl, 1 frame_err, 2 load_done, 3 scan_out
    typedef struct {
        int unsigned when;
        int          inst;
        string       name;
        logic [3:0]  mask;
        logic [11:0] ctrl;
        logic        ferr;
        logic        done;
        logic        sout;
    } exp_t;

    exp_t        obs_q[$];
    logic [11:0] done_q0[$];
    logic [11:0] done_q1[$];
    int checks   = 0;
    int failures = 0;

    function automatic void sb_push(input int inst, input string name, input logic [3:0] mask,
                                    input logic [11:0] c, input logic f, input logic d, input logic s);
        exp_t e;
        e.when = cyc; e.inst = inst; e.name = name; e.mask = mask;
        e.ctrl = c; e.ferr = f; e.done = d; e.sout = s;
        obs_q.push_back(e);
    endfunction

    exp_t        e;
    logic [11:0] ac;
    logic        af, ad, as_;
    logic [11:0] dexp;
    bit          ok;

    always @(negedge clk) begin
        while (obs_q.size() > 0 && obs_q[0].when <= cyc) begin
            e = obs_q.pop_front();
            if (e.inst == 0) begin ac = ia.CTRL; af = ia.FRAME_ERR; ad = ia.LOAD_DONE; as_ = ia.SCAN_OUT; end
            else             begin ac = ib.CTRL; af = ib.FRAME_ERR; ad = ib.LOAD_DONE; as_ = ib.SCAN_OUT; end
            ok = (e.when == cyc);
            if (e.mask[0] && ac  !== e.ctrl) ok = 0;
            if (e.mask[1] && af  !== e.ferr) ok = 0;
            if (e.mask[2] && ad  !== e.done) ok = 0;
            if (e.mask[3] && as_ !== e.sout) ok = 0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s (inst %0d cyc %0d): got ctrl=%h ferr=%b done=%b sout=%b, want ctrl=%h ferr=%b done=%b sout=%b mask=%b",
                         e.name, e.inst, cyc, ac, af, ad, as_, e.ctrl, e.ferr, e.done, e.sout, e.mask);
            end
        end
        if (ia.LOAD_DONE === 1'b1) begin
            checks++;
            if (done_q0.size() == 0) begin
                failures++;
                $display("FAIL done_a_unexpected: got LOAD_DONE=1 ctrl=%h, want no pulse", ia.CTRL);
            end else begin
                dexp = done_q0.pop_front();
                if (ia.CTRL !== dexp) begin
                    failures++;
                    $display("FAIL done_a_ctrl: got ctrl=%h, want %h", ia.CTRL, dexp);
                end
            end
        end
        if (ib.LOAD_DONE === 1'b1) begin
            checks++;
            if (done_q1.size() == 0) begin
                failures++;
                $display("FAIL done_b_unexpected: got LOAD_DONE=1 ctrl=%h, want no pulse", ib.CTRL);
            end else begin
                dexp = done_q1.pop_front();
                if (ib.CTRL !== dexp) begin
                    failures++;
                    $display("FAIL done_b_ctrl: got ctrl=%h, want %h", ib.CTRL, dexp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_a(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ia.SCAN_EN = 1'b1;
            ia.SCAN_IN = v[i];
            tick();
        end
        ia.SCAN_EN = 1'b0;
    endtask

    task automatic shift_b(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ib.SCAN_EN = 1'b1;
            ib.SCAN_IN = v[i];
            tick();
        end
    endtask

    // LOAD high for 3 cycles; commit lands on the 3rd edge (2 after first sample).
    task automatic load_a(input string nm, input logic [11:0] old_c, input logic [11:0] new_c, input logic good);
        if (good) done_q0.push_back(new_c);
        ia.LOAD = 1'b1;
        tick();
        tick();
        sb_push(0, {nm, "_pre"}, 4'b0101, old_c, 1'b0, 1'b0, 1'b0);
        tick();
        sb_push(0, {nm, "_commit"}, 4'b0111, good ? new_c : old_c, ~good, good, 1'b0);
        ia.LOAD = 1'b0;
        tick();
        sb_push(0, {nm, "_after"}, 4'b0111, good ? new_c : old_c, ~good, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    logic [11:0] pat;

    initial begin
        ia.SCAN_EN = 0; ia.SCAN_IN = 0; ia.LOAD = 0; ia.CAPTURE = 0;
        ib.SCAN_EN = 0; ib.SCAN_IN = 0; ib.LOAD = 0; ib.CAPTURE = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb_push(0, "reset_a", 4'b1111, 12'h000, 1'b0, 1'b0, 1'b0);
        sb_push(1, "reset_b", 4'b1111, 12'h801, 1'b0, 1'b0, 1'b0);
        tick();

        shift_a(16'h0A5C, 12);
        load_a("load_a5c", 12'h000, 12'hA5C, 1'b1);
        shift_a(16'h0123, 11);
        load_a("short11", 12'hA5C, 12'hA5C, 1'b0);
        shift_a(16'h1FFF, 13);
        load_a("over13", 12'hA5C, 12'hA5C, 1'b0);
        shift_a(16'h03F0, 12);
        load_a("load_3f0", 12'hA5C, 12'h3F0, 1'b1);

        ia.CAPTURE = 1'b1;
        tick();
        ia.CAPTURE = 1'b0;
        pat = 12'h3F0;
        for (int i = 11; i >= 0; i--) begin
            sb_push(0, "capture_sout", 4'b1000, 12'h000, 1'b0, 1'b0, pat[i]);
            ia.SCAN_EN = 1'b1;
            ia.SCAN_IN = 1'b0;
            tick();
        end
        ia.SCAN_EN = 1'b0;
        load_a("load_zero", 12'h3F0, 12'h000, 1'b1);

        shift_a(16'h05A3, 12);
        done_q0.push_back(12'h5A3);
        ia.LOAD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            sb_push(0, "hold_load", 4'b0100, 12'h000, 1'b0, (i == 2), 1'b0);
        end
        rst = 1'b1;
        sb_push(0, "reset_mid_a", 4'b1111, 12'h000, 1'b0, 1'b0, 1'b0);
        sb_push(1, "reset_mid_b", 4'b0111, 12'h801, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        sb_push(0, "load_across_reset", 4'b0111, 12'h000, 1'b1, 1'b0, 1'b0);
        ia.LOAD = 1'b0;
        tick();
        tick();

        // Instance B: LOAD rises on the edge after the 12th shift with SCAN_EN still high.
        shift_b(16'h06B9, 12);
        ib.SCAN_IN = 1'b1;
        ib.LOAD = 1'b1;
        done_q1.push_back(12'h6B9);
        tick();
        sb_push(1, "b_same_edge", 4'b0111, 12'h6B9, 1'b0, 1'b1, 1'b0);
        ib.LOAD = 1'b0;
        shift_b(16'h0234, 11);
        ib.SCAN_EN = 1'b0;
        ib.LOAD = 1'b1;
        done_q1.push_back(12'hA34);
        tick();
        sb_push(1, "b_cnt_from_one", 4'b0111, 12'hA34, 1'b0, 1'b1, 1'b0);
        ib.LOAD = 1'b0;
        tick();
        sb_push(1, "b_done_clear", 4'b0100, 12'h000, 1'b0, 1'b0, 1'b0);

        shift_b(16'h00F5, 12);
        ib.SCAN_EN = 1'b0;
        ib.LOAD = 1'b1;
        ib.CAPTURE = 1'b1;
        done_q1.push_back(12'h0F5);
        tick();
        sb_push(1, "b_cap_load", 4'b1111, 12'h0F5, 1'b0, 1'b1, 1'b1);
        ib.LOAD = 1'b0;
        ib.CAPTURE = 1'b0;
        ib.SCAN_EN = 1'b1;
        ib.SCAN_IN = 1'b0;
        tick();
        sb_push(1, "b_cap_old_bit10", 4'b1000, 12'h000, 1'b0, 1'b0, 1'b0);
        tick();
        sb_push(1, "b_cap_old_bit9", 4'b1000, 12'h000, 1'b0, 1'b0, 1'b1);
        ib.SCAN_EN = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #1;

        checks++;
        if (done_q0.size() != 0) begin
            failures++;
            $display("FAIL done_a_missing: got %0d pulses outstanding, want 0", done_q0.size());
        end
        checks++;
        if (done_q1.size() != 0) begin
            failures++;
            $display("FAIL done_b_missing: got %0d pulses outstanding, want 0", done_q1.size());
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL obs_unchecked: got %0d entries left, want 0", obs_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/scan_ctrl_chain.md
Name: scan_ctrl_chain

Overview:
- Parametrised serial-scan control register: shift chain, shadow output register and frame check, all in one clock.
- Configuration bits are shifted in serially on SCAN_IN and then committed in parallel to CTRL on a LOAD strobe.
- A load is committed only when exactly WIDTH bits were shifted since the previous load or capture.
- Also supports CTRL readback (CAPTURE) and daisy-chaining through SCAN_OUT. Sits between the chip scan pads and the core control inputs.

Parameters:
- WIDTH, 12, number of control bits (chain length); WIDTH >= 2.
- RESET_VAL, 0 (WIDTH bits), value CTRL takes on reset.
- SYNC_LOAD, 1, 1 = LOAD passes through a 2-flop synchroniser before edge detection; 0 = LOAD is sampled directly by one edge-detect flop.

Ports:
- SCAN_CLK  in  1  clock; all flops on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SCAN_EN  in  1  1 = shift one bit per SCAN_CLK.
- SCAN_IN  in  1  serial data in, MSB first.
- LOAD  in  1  commit request, level from pad; rising edge is the event.
- CAPTURE  in  1  synchronous level; copies CTRL into the chain when SCAN_EN=0.
- SCAN_OUT  out  1  SR[WIDTH-1], for daisy chain and readback.
- CTRL  out  WIDTH  committed control word.
- FRAME_ERR  out  1  sticky; set by a load attempt with a wrong bit count.
- LOAD_DONE  out  1  one-cycle pulse after a successful commit.

Behaviour:
- Reset (async, RESET=1) forces these values: SR=0, CTRL=RESET_VAL, CNT=0, FRAME_ERR=0, LOAD_DONE=0, all sync and edge-detect flops=0. SCAN_OUT=0.
- Shift, when SCAN_EN=1:
  - SR <= {SR[WIDTH-2:0], SCAN_IN}. The first bit shifted lands in CTRL[WIDTH-1] after WIDTH shifts.
  - SCAN_OUT presents the bit shifted in WIDTH edges earlier.
- Bit counter CNT is clog2(WIDTH+2) bits wide. It increments on each shift and saturates at WIDTH+1, which encodes overshift.
- Load event detection:
  - Edge-detect stage: p = ls & ~lprev.
  - SYNC_LOAD=1: ls is the 2nd synchroniser flop. If LOAD is first sampled high at edge k, the commit happens at edge k+2.
  - SYNC_LOAD=0: ls = LOAD. The commit happens at the first edge that sees LOAD high.
  - LOAD held high produces exactly one event. A new event requires LOAD to go low for at least one sample first.
- At a load event:
  - If CNT==WIDTH: CTRL <= SR, FRAME_ERR <= 0, LOAD_DONE=1 for the next cycle.
  - Otherwise: CTRL holds, FRAME_ERR <= 1, LOAD_DONE stays 0.
  - In both cases CNT <= (SCAN_EN ? 1 : 0).
- Capture:
  - CAPTURE=1 with SCAN_EN=0: SR <= CTRL (pre-edge value), CNT <= 0.
  - CAPTURE with SCAN_EN=1 is ignored; shift has priority.
- Simultaneous events at one edge:
  - The load event uses the pre-edge SR and CNT.
  - Shift and capture update SR in the same edge.
  - Capture together with a load copies the old CTRL, not the newly committed value.
- FRAME_ERR clears only on reset or on a successful commit.
- Reset mid-shift discards the partial frame.
- LOAD held high across reset release:
  - One event fires after release; with SYNC_LOAD=1 it fires at the 2nd edge after release.
  - Because CNT=0, this sets FRAME_ERR and CTRL stays at RESET_VAL.
- With SCAN_EN=0, CAPTURE=0 and no load event, all state holds.

Test Plan:
- WIDTH=12, SYNC_LOAD=1:
  - Reset release -> CTRL=12'h000, FRAME_ERR=0, LOAD_DONE=0, SCAN_OUT=0.
  - Shift 12 bits of 12'hA5C MSB first, then pulse LOAD high for 3 cycles -> CTRL=12'hA5C exactly 2 edges after LOAD is first sampled high; LOAD_DONE high for 1 cycle; FRAME_ERR=0.
  - Shift 11 bits then LOAD -> CTRL stays 12'hA5C and FRAME_ERR=1. Shift 13 bits then LOAD -> same result. Then shift a correct 12-bit frame 12'h3F0 and LOAD -> CTRL=12'h3F0, FRAME_ERR=0.
  - With CTRL=12'h3F0: CAPTURE for 1 cycle, then shift 12 cycles with SCAN_IN=0 -> SCAN_OUT emits 0,0,1,1,1,1,1,1,0,0,0,0 (MSB first). LOAD then -> CTRL=12'h000.
  - Hold LOAD high for 20 cycles after a valid frame -> exactly one LOAD_DONE pulse. Assert RESET while LOAD is high, then release -> FRAME_ERR=1, CTRL=RESET_VAL.
- SYNC_LOAD=0, RESET_VAL=12'h801:
  - Reset -> CTRL=12'h801.
  - Shift 12 bits; on the same edge as LOAD rises, keep SCAN_EN=1 -> CTRL=frame value at that edge, then CNT=1.
